// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754 multiplier with valid/ready handshake, RNE rounding and subnormal support.
// Define FP_MUL_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * M;
  localparam int XW = M + 3;

  localparam logic signed [EW-1:0] ONE     = EW'(1);
  localparam logic signed [EW-1:0] BIAS    = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] XW_E    = EW'(XW);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULT, NORM_P, ROUND, PACK, DONE
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]           a_reg, b_reg, z_reg;
  logic signed [EW-1:0]   ea_reg, eb_reg, exp_reg;
  logic [M-1:0]           ma_reg, mb_reg, mant_reg;
  logic [PW-1:0]          prod_reg;
  logic                   g_reg, r_reg, s_reg;
`ifdef FP_MUL_FLAGS_EN
  logic                   tiny_reg, inexact_reg;
  logic [3:0]             flag_reg;
`endif

  // Operand classification and unpacking, one lane per operand
  logic [W-1:0]           op_word [2];
  logic [1:0]             op_sign, is_nan, is_inf, is_zero;
  logic signed [EW-1:0]   unb_exp [2];
  logic [M-1:0]           unp_mant [2];

  assign op_word[0] = a_reg;
  assign op_word[1] = b_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic [EXP_W-1:0] exp_f;
      logic [MAN_W-1:0] frac_f;
      logic             exp_max, exp_zero, frac_zero;
      assign exp_f        = op_word[gi][W-2 -: EXP_W];
      assign frac_f       = op_word[gi][MAN_W-1:0];
      assign exp_max      = &exp_f;
      assign exp_zero     = ~|exp_f;
      assign frac_zero    = ~|frac_f;
      assign op_sign[gi]  = op_word[gi][W-1];
      assign is_nan[gi]   = exp_max & ~frac_zero;
      assign is_inf[gi]   = exp_max & frac_zero;
      assign is_zero[gi]  = exp_zero & frac_zero;
      assign unb_exp[gi]  = exp_zero ? (ONE - BIAS) : ($signed({2'b00, exp_f}) - BIAS);
      assign unp_mant[gi] = {~exp_zero, frac_f};
    end
  endgenerate

  logic         sgn, sp_nan, sp_hit;
  logic [W-1:0] sp_z;

  assign sgn    = op_sign[0] ^ op_sign[1];
  assign sp_nan = (|is_nan) | (is_inf[0] & is_zero[1]) | (is_inf[1] & is_zero[0]);
  assign sp_hit = sp_nan | (|is_inf) | (|is_zero);

  always_comb begin
    sp_z = {sgn, {(W-1){1'b0}}};
    if (sp_nan) begin
      sp_z = QNAN;
    end else if (|is_inf) begin
      sp_z = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Product normalisation plus the denormalising right shift for tiny results
  logic                  np_top, np_g, np_r, np_s, np_tiny;
  logic signed [EW-1:0]  np_exp, np_sh;
  logic [M-1:0]          np_mant;
  logic [EW-1:0]         sh_c;
  logic [2*XW-1:0]       sh_vec;

  always_comb begin
    np_top  = prod_reg[PW-1];
    np_exp  = exp_reg + BIAS + (np_top ? ONE : '0);
    np_mant = np_top ? prod_reg[PW-1 -: M] : prod_reg[PW-2 -: M];
    np_g    = np_top ? prod_reg[M-1] : prod_reg[M-2];
    np_r    = np_top ? prod_reg[M-2] : prod_reg[M-3];
    np_s    = np_top ? (|prod_reg[M-3:0]) : (|prod_reg[M-4:0]);
    np_tiny = (np_exp < ONE);
    np_sh   = ONE - np_exp;
    sh_c    = '0;
    if (np_tiny) begin
      sh_c = (np_sh > XW_E) ? XW_E : np_sh;
    end
    sh_vec  = {np_mant, np_g, np_r, np_s, {XW{1'b0}}} >> sh_c;
  end

  logic                 rd_inc;
  logic [M:0]           rd_sum;
  logic [M-1:0]         rd_mant;
  logic signed [EW-1:0] rd_exp;

  always_comb begin
    rd_inc  = g_reg & (r_reg | s_reg | mant_reg[0]);
    rd_sum  = {1'b0, mant_reg} + {{M{1'b0}}, rd_inc};
    rd_mant = rd_sum[M] ? rd_sum[M:1] : rd_sum[M-1:0];
    rd_exp  = rd_sum[M] ? (exp_reg + ONE) : exp_reg;
  end

  logic         pk_ovf;
  logic [W-1:0] pk_z;

  always_comb begin
    pk_ovf = (exp_reg >= EXP_MAX);
    if (pk_ovf) begin
      pk_z = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (!mant_reg[M-1]) begin
      pk_z = {sgn, {EXP_W{1'b0}}, mant_reg[MAN_W-1:0]};
    end else begin
      pk_z = {sgn, exp_reg[EXP_W-1:0], mant_reg[MAN_W-1:0]};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: state_next = sp_hit ? DONE : NORM_A;
      NORM_A:  if (ma_reg[M-1]) state_next = NORM_B;
      NORM_B:  if (mb_reg[M-1]) state_next = MULT;
      MULT:    state_next = NORM_P;
      NORM_P:  state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      z_reg     <= '0;
      ea_reg    <= '0;
      eb_reg    <= '0;
      exp_reg   <= '0;
      ma_reg    <= '0;
      mb_reg    <= '0;
      mant_reg  <= '0;
      prod_reg  <= '0;
      g_reg     <= 1'b0;
      r_reg     <= 1'b0;
      s_reg     <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
      tiny_reg    <= 1'b0;
      inexact_reg <= 1'b0;
      flag_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        UNPACK: begin
          ea_reg <= unb_exp[0];
          eb_reg <= unb_exp[1];
          ma_reg <= unp_mant[0];
          mb_reg <= unp_mant[1];
        end
        SPECIAL: begin
          if (sp_hit) begin
            z_reg <= sp_z;
`ifdef FP_MUL_FLAGS_EN
            flag_reg <= {sp_nan, 3'b000};
`endif
          end
        end
        NORM_A: begin
          if (!ma_reg[M-1]) begin
            ma_reg <= ma_reg << 1;
            ea_reg <= ea_reg - ONE;
          end
        end
        NORM_B: begin
          if (!mb_reg[M-1]) begin
            mb_reg <= mb_reg << 1;
            eb_reg <= eb_reg - ONE;
          end
        end
        MULT: begin
          exp_reg  <= ea_reg + eb_reg;
          prod_reg <= PW'(ma_reg) * PW'(mb_reg);
        end
        NORM_P: begin
          mant_reg <= sh_vec[2*XW-1 -: M];
          g_reg    <= sh_vec[XW+2];
          r_reg    <= sh_vec[XW+1];
          s_reg    <= |sh_vec[XW:0];
          exp_reg  <= np_tiny ? ONE : np_exp;
`ifdef FP_MUL_FLAGS_EN
          tiny_reg    <= np_tiny;
          inexact_reg <= sh_vec[XW+2] | sh_vec[XW+1] | (|sh_vec[XW:0]);
`endif
        end
        ROUND: begin
          mant_reg <= rd_mant;
          exp_reg  <= rd_exp;
        end
        PACK: begin
          z_reg <= pk_z;
`ifdef FP_MUL_FLAGS_EN
          flag_reg <= {1'b0, pk_ovf, tiny_reg & inexact_reg, inexact_reg | pk_ovf};
`endif
        end
        DONE: begin
`ifdef FP_MUL_FLAGS_EN
          if (out_ready) flag_reg <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE) && !rst;
  assign z         = z_reg;
`ifdef FP_MUL_FLAGS_EN
  assign flags     = flag_reg;
`endif

endmodule

// File: doc/fp_mul_param.md
Name: fp_mul_param

Overview:
Parametrised, handshaked IEEE-754 binary floating-point multiplier (default binary32) built as a multi-cycle FSM. Generalises the single-precision multiplier to any exponent/mantissa width. Adds valid/ready flow control, round-to-nearest-even, subnormal inputs and outputs, and canonical special-value handling. Sits in the datapath as a shared FP multiply unit behind an upstream issue stage.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit excluded); word width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a,b present
in_ready  output  1  block can accept operands
a  input  W  multiplicand, IEEE format
b  input  W  multiplier, IEEE format
out_valid  output  1  z holds a result
out_ready  input  1  consumer takes z
z  output  W  product, IEEE format

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, out_valid=0, z=0, in_ready=0 while rst=1.
- rst mid-operation abandons the operation; no result is ever presented for it.
- in_ready=1 only in IDLE.
- Accept on the edge where in_valid&&in_ready; a and b are registered then. Later input changes are ignored.
- States, one cycle each unless noted: IDLE -> UNPACK -> SPECIAL -> NORM_A -> NORM_B -> MULT -> NORM_P -> ROUND -> PACK -> DONE.
- UNPACK: split fields; unbiased exponent kept signed, EXP_W+2 bits. Subnormal (exp field 0, frac!=0) gets exponent 1-bias and hidden bit 0; normal gets hidden bit 1.
- SPECIAL: checks in priority order, then jumps straight to DONE:
  - any NaN operand -> canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0)
  - inf×0 -> canonical qNaN
  - inf×anything else -> ±inf
  - 0×finite -> ±0
  - sign of ±inf and ±0 = sign_a^sign_b
  - otherwise -> NORM_A.
- NORM_A / NORM_B: while hidden bit is 0, shift mantissa left 1 and decrement exponent, staying in the state; exit when hidden bit is 1. Cost: 1 cycle + 1 per shift.
- MULT: sign = sa^sb; exp = ea+eb; product = 2(MAN_W+1)-bit full product.
- NORM_P: if product MSB set, exp+1 and take upper bits; else take next bits. Capture guard, round, sticky (OR of all lower bits).
  - If biased exp <= 0: right-shift the mantissa by 1-biased_exp in one cycle (barrel), folding shifted-out bits into guard/round/sticky. A shift of MAN_W+3 or more yields mantissa 0 with sticky = any nonzero bit.
- ROUND: RNE; increment when guard && (round|sticky|lsb). Carry out of the mantissa -> shift right 1, exp+1. A subnormal rounding into hidden bit 1 becomes min normal (exp field 1).
- PACK: biased exp >= all-ones -> ±inf (frac 0); hidden bit 0 -> exp field 0; else normal encoding.
- DONE: out_valid=1, z stable until out_ready=1. On out_valid&&out_ready, out_valid goes 0 and the state returns to IDLE; in_ready rises the next cycle.
- Latency, counted in edges from the accept edge to the edge that raises out_valid:
  - normal×normal: 8
  - special case: 2
  - plus 1 per subnormal normalisation shift
- Throughput: one operation in flight.

Optional Feature:
FP_MUL_FLAGS_EN:
- Defined: adds output flags [3:0] = {invalid, overflow, underflow, inexact}.
  - Flags are registered with z, valid while out_valid, reset 0, cleared on handshake.
  - invalid = NaN operand or inf×0.
  - overflow = finite operands rounding to inf.
  - underflow = tiny and inexact.
  - inexact = guard|round|sticky != 0 or overflow.
- Undefined: port and flag logic absent; z and timing identical.

Test Plan:
1. a=0x40400000 (3.0), b=0x40200000 (2.5), out_ready=1 -> z=0x40F00000, out_valid 8 edges after accept.
2. a=0x7F800000, b=0x00000000 -> z=0x7FC00000 after 2 edges; with FP_MUL_FLAGS_EN, flags=4'b1000.
3. a=0x7F7FFFFF, b=0x40000000 -> z=0x7F800000; flags=4'b0101.
4. a=0x00000001 (subnormal), b=0x4B000000 (2^23) -> z=0x00800000, latency 8+23=31.
5. RNE tie: a=0x3F800001, b=0x40400000 -> z=0x40400002; a=0x3F800001, b=0x3F800001 -> z=0x3F800002.
6. Flow control:
   - Hold out_ready=0 for 10 cycles with in_valid=1 and new operands -> z and out_valid stable, in_ready=0, operands not accepted.
   - Release out_ready -> in_ready=1 next cycle.
   - Assert rst 3 cycles after a new accept -> out_valid never rises, in_ready=1 after rst drops.
